// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, RV32I field constants and the
// instruction-to-ALUop decode used by the decode stage and the ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD     = 4'b1001;
  localparam logic [3:0] ALU_SUB     = 4'b0001;
  localparam logic [3:0] ALU_XOR     = 4'b0010;
  localparam logic [3:0] ALU_OR      = 4'b0011;
  localparam logic [3:0] ALU_AND     = 4'b0100;
  localparam logic [3:0] ALU_SLL     = 4'b0101;
  localparam logic [3:0] ALU_SRL     = 4'b1101;
  localparam logic [3:0] ALU_DEFAULT = 4'b1111;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // Where operand B comes from.
  typedef enum logic [1:0] {
    SRC_REG   = 2'd0,
    SRC_SIMM  = 2'd1,
    SRC_SHAMT = 2'd2
  } src_e;

  typedef struct packed {
    logic [3:0] aluop;
    logic       illegal;
    src_e       src2;
  } dec_t;

  // Anything not explicitly recognised falls through to ALU_DEFAULT/illegal.
  function automatic dec_t decode_op(input logic [31:0] inst);
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    dec_t       d;
    opc     = inst[6:0];
    f3      = inst[14:12];
    f7      = inst[31:25];
    d.aluop = ALU_DEFAULT;
    d.src2  = SRC_REG;
    if (opc == OP_R) begin
      if (f7 == F7_BASE) begin
        case (f3)
          F3_ADD:  d.aluop = ALU_ADD;
          F3_XOR:  d.aluop = ALU_XOR;
          F3_OR:   d.aluop = ALU_OR;
          F3_AND:  d.aluop = ALU_AND;
          F3_SLL:  d.aluop = ALU_SLL;
          F3_SRL:  d.aluop = ALU_SRL;
          default: d.aluop = ALU_DEFAULT;
        endcase
      end else if (f7 == F7_SUB && f3 == F3_ADD) begin
        d.aluop = ALU_SUB;
      end
    end else if (opc == OP_I) begin
      case (f3)
        F3_ADD: begin d.aluop = ALU_ADD; d.src2 = SRC_SIMM; end
        F3_XOR: begin d.aluop = ALU_XOR; d.src2 = SRC_SIMM; end
        F3_OR:  begin d.aluop = ALU_OR;  d.src2 = SRC_SIMM; end
        F3_AND: begin d.aluop = ALU_AND; d.src2 = SRC_SIMM; end
        F3_SLL: if (f7 == F7_BASE) begin d.aluop = ALU_SLL; d.src2 = SRC_SHAMT; end
        F3_SRL: if (f7 == F7_BASE) begin d.aluop = ALU_SRL; d.src2 = SRC_SHAMT; end
        default: d.aluop = ALU_DEFAULT;
      endcase
    end
    d.illegal = (d.aluop == ALU_DEFAULT);
    return d;
  endfunction

endpackage

// File: rtl/regfile.sv
// Integer register file: two combinational read ports, one synchronous
// write port, x0 hardwired to zero.
module regfile
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NREGS];

  // Write port; writes to x0 are dropped so x0 stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/alu_decode_stage.sv
// Decode / operand-fetch stage in front of the ALU. Decode and operand
// selection are combinational into a single skid-free output register.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic [3:0]      ALUop,
  output logic [AW-1:0]   rd,
  output logic            illegal
);

  function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
    return {{(XLEN-12){v[11]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext5(input logic [4:0] v);
    return {{(XLEN-5){1'b0}}, v};
  endfunction

  logic [AW-1:0]   ra1, ra2, rdi;
  logic [XLEN-1:0] rf1, rf2, opa, opb;
  logic [XLEN-1:0] rs1_d, rs2_d;
  logic [AW-1:0]   rd_d;
  dec_t            dec;

  logic            vld_p0;
  logic [XLEN-1:0] rs1_p0, rs2_p0;
  logic [3:0]      aluop_p0;
  logic [AW-1:0]   rd_p0;
  logic            ill_p0;

  assign ra1 = in_inst[15 +: AW];
  assign ra2 = in_inst[20 +: AW];
  assign rdi = in_inst[7 +: AW];
  assign dec = decode_op(in_inst);

  regfile #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (rf1),
    .rd2   (rf2),
    .we    (wb_en),
    .wa    (wb_rd),
    .wd    (wb_data)
  );

  // Operand fetch with same-cycle writeback bypass, then squash on illegal.
  always_comb begin
    opa   = rf1;
    opb   = rf2;
    rs1_d = '0;
    rs2_d = '0;
    rd_d  = '0;
    if (wb_en && wb_rd != '0 && wb_rd == ra1) opa = wb_data;
    if (wb_en && wb_rd != '0 && wb_rd == ra2) opb = wb_data;
    if (!dec.illegal) begin
      rs1_d = opa;
      rd_d  = rdi;
      case (dec.src2)
        SRC_SIMM:  rs2_d = sext12(in_inst[31:20]);
        SRC_SHAMT: rs2_d = zext5(in_inst[24:20]);
        default:   rs2_d = opb;
      endcase
    end
  end

  assign in_ready = !vld_p0 || out_ready;

  // ---- stage p0: bundle register toward the ALU ----
  // Load on every accept; hold everything while the ALU stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      rs1_p0   <= '0;
      rs2_p0   <= '0;
      aluop_p0 <= ALU_DEFAULT;
      rd_p0    <= '0;
      ill_p0   <= 1'b0;
    end else if (in_ready) begin
      vld_p0 <= in_valid;
      if (in_valid) begin
        rs1_p0   <= rs1_d;
        rs2_p0   <= rs2_d;
        aluop_p0 <= dec.aluop;
        rd_p0    <= rd_d;
        ill_p0   <= dec.illegal;
      end
    end
  end

  assign out_valid = vld_p0;
  assign rs1       = rs1_p0;
  assign rs2       = rs2_p0;
  assign ALUop     = aluop_p0;
  assign rd        = rd_p0;
  assign illegal   = ill_p0;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: the driver pushes the expected
// bundle for every accepted instruction, the monitor pops on every transfer-out.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [3:0]  ALUop;
  logic [4:0]  rd;
  logic        illegal;

  always #5 clk = ~clk;

  alu_decode_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .ALUop     (ALUop),
    .rd        (rd),
    .illegal   (illegal)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  localparam exp_t ILL = {32'd0, 32'd0, 4'hF, 5'd0, 1'b1};

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   stall = 0;
  int   nbund = 0;

  function automatic exp_t E(input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] op, input logic [4:0] r);
    return {a, b, op, r, 1'b0};
  endfunction

  function automatic logic [31:0] rt(input logic [6:0] f7, input logic [4:0] r2,
                                     input logic [4:0] r1, input logic [2:0] f3,
                                     input logic [4:0] rdx);
    return {f7, r2, r1, f3, rdx, 7'b0110011};
  endfunction

  function automatic logic [31:0] it(input logic [11:0] imm, input logic [4:0] r1,
                                     input logic [2:0] f3, input logic [4:0] rdx);
    return {imm, r1, f3, rdx, 7'b0010011};
  endfunction

  task automatic check(input string name, input logic [73:0] act, input logic [73:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, want);
    end
  endtask

  // One instruction and/or writeback; retries while in_ready is low.
  task automatic drive(input logic v, input logic [31:0] inst, input exp_t e,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd);
    int   guard;
    logic acc;
    guard = 0;
    @(negedge clk);
    in_valid = v;
    in_inst  = inst;
    wb_en    = we;
    wb_rd    = wr;
    wb_data  = wd;
    forever begin
      if (stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else begin
        out_ready = 1'b1;
      end
      #4;
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) q.push_back(e);
      if (acc || !v) break;
      guard++;
      if (guard > 20) begin
        total++;
        bad++;
        $display("FAIL accept_timeout inst=%h actual=not_accepted required=accepted", inst);
        break;
      end
      @(negedge clk);
    end
    #1;
    in_valid = 1'b0;
    wb_en    = 1'b0;
  endtask

  task automatic send(input logic [31:0] inst, input exp_t e);
    drive(1'b1, inst, e, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    drive(1'b0, 32'd0, '0, 1'b1, r, d);
  endtask

  // Monitor: pop on transfer-out, and check stability while stalled.
  initial begin
    exp_t got, held, want;
    logic have_held;
    have_held = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n !== 1'b1) begin
        have_held = 1'b0;
        continue;
      end
      got = {rs1, rs2, ALUop, rd, illegal};
      if (out_valid && !out_ready) begin
        check("stall_in_ready", {73'd0, in_ready}, 74'd0);
        if (have_held) check("hold_stable", got, held);
        held      = got;
        have_held = 1'b1;
      end else begin
        have_held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_bundle actual=%h required=none", got);
        end else begin
          want = q.pop_front();
          check($sformatf("bundle%0d", nbund), got, want);
          nbund++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = 32'd0;
    wb_en     = 1'b0;
    wb_rd     = 5'd0;
    wb_data   = 32'd0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_out_valid", {73'd0, out_valid}, 74'd0);
    check("reset_in_ready",  {73'd0, in_ready},  74'd1);
    check("reset_bundle", {rs1, rs2, ALUop, rd, illegal}, {32'd0, 32'd0, 4'hF, 5'd0, 1'b0});
    rst_n = 1'b1;

    // Immediates, writeback, and R-type ops.
    send(32'h00C00093, E(32'd0, 32'd12, 4'b1001, 5'd1));
    send(32'h01200113, E(32'd0, 32'd18, 4'b1001, 5'd2));
    wb(5'd1, 32'd12);
    wb(5'd2, 32'd18);
    send(32'h002081B3, E(32'd12, 32'd18, 4'b1001, 5'd3));
    send(32'h402081B3, E(32'd12, 32'd18, 4'b0001, 5'd3));
    send(rt(7'd0, 5'd2, 5'd1, 3'b100, 5'd3), E(32'd12, 32'd18, 4'b0010, 5'd3));
    send(rt(7'd0, 5'd2, 5'd1, 3'b110, 5'd3), E(32'd12, 32'd18, 4'b0011, 5'd3));
    send(rt(7'd0, 5'd2, 5'd1, 3'b111, 5'd3), E(32'd12, 32'd18, 4'b0100, 5'd3));
    send(rt(7'd0, 5'd2, 5'd1, 3'b001, 5'd3), E(32'd12, 32'd18, 4'b0101, 5'd3));
    send(rt(7'd0, 5'd2, 5'd1, 3'b101, 5'd3), E(32'd12, 32'd18, 4'b1101, 5'd3));

    // Shifts and immediates of both signs.
    send(it(12'd2, 5'd1, 3'b001, 5'd4), E(32'd12, 32'd2, 4'b0101, 5'd4));
    send(it(12'd3, 5'd1, 3'b101, 5'd4), E(32'd12, 32'd3, 4'b1101, 5'd4));
    send(it(12'hFFF, 5'd1, 3'b000, 5'd1), E(32'd12, 32'hFFFF_FFFF, 4'b1001, 5'd1));
    send(it(12'h7FF, 5'd2, 3'b100, 5'd5), E(32'd18, 32'h0000_07FF, 4'b0010, 5'd5));
    send(it(12'h800, 5'd2, 3'b110, 5'd5), E(32'd18, 32'hFFFF_F800, 4'b0011, 5'd5));
    send(it(12'd5, 5'd1, 3'b111, 5'd5), E(32'd12, 32'd5, 4'b0100, 5'd5));

    // Back-pressure: add is held 3 cycles while x1 is rewritten underneath it.
    send(32'h002081B3, E(32'd12, 32'd18, 4'b1001, 5'd3));
    stall = 3;
    drive(1'b1, 32'h402081B3, E(32'd50, 32'd18, 4'b0001, 5'd3), 1'b1, 5'd1, 32'd50);
    send(rt(7'd0, 5'd2, 5'd1, 3'b100, 5'd3), E(32'd50, 32'd18, 4'b0010, 5'd3));
    send(rt(7'd0, 5'd2, 5'd1, 3'b110, 5'd3), E(32'd50, 32'd18, 4'b0011, 5'd3));

    // Bypass on the accept cycle, then confirm the write landed.
    drive(1'b1, 32'h002081B3, E(32'd100, 32'd18, 4'b1001, 5'd3), 1'b1, 5'd1, 32'd100);
    send(it(12'd0, 5'd1, 3'b000, 5'd8), E(32'd100, 32'd0, 4'b1001, 5'd8));

    // x0 ignores writes.
    wb(5'd0, 32'd55);
    send(rt(7'd0, 5'd0, 5'd0, 3'b000, 5'd7), E(32'd0, 32'd0, 4'b1001, 5'd7));

    // Illegal encodings: sra, load opcode, funct7 mismatch, slt, srai.
    send(rt(7'b0100000, 5'd2, 5'd1, 3'b101, 5'd3), ILL);
    send(32'h00012083, ILL);
    send(rt(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3), ILL);
    send(rt(7'd0, 5'd2, 5'd1, 3'b010, 5'd3), ILL);
    send(it(12'h405, 5'd1, 3'b101, 5'd4), ILL);

    // Reset mid-stream with a bundle in flight.
    wb(5'd5, 32'd77);
    send(rt(7'd0, 5'd0, 5'd5, 3'b000, 5'd6), E(32'd77, 32'd0, 4'b1001, 5'd6));
    #1;
    check("pre_reset_valid", {73'd0, out_valid}, 74'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", {73'd0, out_valid}, 74'd0);
    check("async_reset_aluop", {70'd0, ALUop}, {70'd0, 4'hF});
    check("async_reset_in_ready", {73'd0, in_ready}, 74'd1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(rt(7'd0, 5'd0, 5'd5, 3'b000, 5'd6), E(32'd0, 32'd0, 4'b1001, 5'd6));
    send(32'h002081B3, E(32'd0, 32'd0, 4'b1001, 5'd3));

    repeat (3) @(negedge clk);
    check("queue_drained", {64'd0, 10'(q.size())}, 74'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
